serial_frame_rx: RTL and testbench

- Receives a framed 1-bit serial stream and presents each frame as a parallel word.
- Frame format: start bit 0, DATA_W data bits LSB first, optional parity bit, stop bit 1.
- The stream is sampled on a bit-strobe, so it can be clocked at any integer fraction of clk.
- Sits after the team's flip-flop/shift-register stimulus chains and checks their serial output in labs and benches.

---
 rtl/serial_frame_rx.sv | 88 ++++++++
 tb/tb_serial_frame_rx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start 0, DATA_W data bits LSB first, optional parity, stop 1.
// Bits are taken only on clk edges that carry bit_en, so the line may run at any clk divisor.
module serial_frame_rx #(
    parameter int DATA_W  = 8,
    parameter int PAR_EN  = 1,
    parameter int PAR_ODD = 0
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              sin,
    input  logic              bit_en,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic              perr,
    output logic              ferr,
    output logic              busy
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] sr, sr_shift;
    logic [CW-1:0]     cnt;
    logic              par_bit;
    logic              perr_calc;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bit_en && !sin) state_nxt = DATA;
            DATA: if (bit_en && cnt == LAST) state_nxt = (PAR_EN != 0) ? PAR : STOP;
            PAR:  if (bit_en) state_nxt = STOP;
            STOP: if (bit_en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Right shift so the first data bit lands at bit 0 after DATA_W strobes.
    always_comb begin
        sr_shift             = sr >> 1;
        sr_shift[DATA_W-1]   = sin;
        perr_calc            = (PAR_EN != 0) && ((^sr ^ par_bit) != PAR_ODD[0]);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sr      <= '0;
            cnt     <= '0;
            par_bit <= 1'b0;
            dout    <= '0;
            valid   <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (bit_en) begin
                case (state)
                    IDLE: if (!sin) begin
                        busy <= 1'b1;
                        cnt  <= '0;
                    end
                    DATA: begin
                        sr  <= sr_shift;
                        cnt <= cnt + 1'b1;
                    end
                    PAR: par_bit <= sin;
                    STOP: begin
                        // A low stop sample is reported, never reused as a start bit.
                        dout  <= sr;
                        valid <= 1'b1;
                        perr  <= perr_calc;
                        ferr  <= !sin;
                        busy  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: frame table plus hand sequences, scoreboard checked on valid.
module tb_serial_frame_rx;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              clr_n = 1'b1;
    logic              sin = 1'b1;
    logic              bit_en = 1'b0;
    logic [DATA_W-1:0] dout;
    logic              valid, perr, ferr, busy;

    serial_frame_rx #(.DATA_W(DATA_W), .PAR_EN(1), .PAR_ODD(0)) dut (
        .clk(clk), .clr_n(clr_n), .sin(sin), .bit_en(bit_en),
        .dout(dout), .valid(valid), .perr(perr), .ferr(ferr), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       flip;   // send the wrong parity bit
        logic       stop;
        logic [7:0] exp_dout;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       f;
    } exp_t;

    exp_t sb[$];
    int   vcyc[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic prev_v = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (valid) begin
            exp_t e;
            vcyc.push_back(cyc);
            check("valid_one_cycle", {31'd0, prev_v}, 32'd0);
            check("busy_at_valid", {31'd0, busy}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got dout %0h expected no frame", dout);
            end else begin
                e = sb.pop_front();
                check("dout", {24'd0, dout}, {24'd0, e.d});
                check("perr", {31'd0, perr}, {31'd0, e.p});
                check("ferr", {31'd0, ferr}, {31'd0, e.f});
            end
        end
        prev_v = valid;
    end

    // One bit: strobe for one clk, then sp-1 idle clks.
    task automatic send_bit(input logic b, input int sp);
        sin    = b;
        bit_en = 1'b1;
        @(posedge clk); #1;
        bit_en = 1'b0;
        for (int i = 1; i < sp; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop,
                              input int sp, input logic [7:0] ed, input logic ep, input logic ef);
        exp_t e;
        e.d = ed; e.p = ep; e.f = ef;
        sb.push_back(e);
        send_bit(1'b0, sp);
        for (int i = 0; i < 8; i++) send_bit(d[i], sp);
        send_bit(^d ^ flip, sp);
        send_bit(stop, sp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    vec_t vt[6];

    initial begin
        vt[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vt[1] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
        vt[2] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
        vt[3] = '{8'h0F, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0};
        vt[4] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vt[5] = '{8'h80, 1'b1, 1'b0, 8'h80, 1'b1, 1'b1};

        // Asynchronous reset mid-cycle with sin unknown
        sin = 1'bx;
        #3 clr_n = 1'b0;
        #1;
        check("rst_dout", {24'd0, dout}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_perr", {31'd0, perr}, 32'd0);
        check("rst_ferr", {31'd0, ferr}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        sin = 1'b1;
        idle(2);
        clr_n = 1'b1;
        idle(2);

        // busy rises with the accepted start bit
        send_bit(1'b1, 1);
        check("busy_idle", {31'd0, busy}, 32'd0);
        begin
            exp_t e;
            e.d = 8'hA5; e.p = 1'b0; e.f = 1'b0;
            sb.push_back(e);
            send_bit(1'b0, 1);
            check("busy_start", {31'd0, busy}, 32'd1);
            for (int i = 0; i < 8; i++) send_bit(vt[0].data[i], 1);
            send_bit(1'b0, 1);
            send_bit(1'b1, 1);
        end
        idle(2);
        check("busy_after", {31'd0, busy}, 32'd0);
        check("dout_hold", {24'd0, dout}, 32'hA5);

        // Table, back-to-back at full rate
        for (int i = 0; i < 6; i++)
            send_frame(vt[i].data, vt[i].flip, vt[i].stop, 1,
                       vt[i].exp_dout, vt[i].exp_perr, vt[i].exp_ferr);
        idle(3);
        check("ferr_hold", {31'd0, ferr}, 32'd1);

        // Strobe every 4th clk, back-to-back 0x12 then 0x34
        send_bit(1'b1, 1);
        vcyc.delete();
        send_frame(8'h12, 1'b0, 1'b1, 4, 8'h12, 1'b0, 1'b0);
        send_frame(8'h34, 1'b0, 1'b1, 4, 8'h34, 1'b0, 1'b0);
        idle(3);
        check("spaced_count", vcyc.size(), 32'd2);
        if (vcyc.size() == 2) check("spaced_gap", vcyc[1] - vcyc[0], 32'd44);

        // Reset after 4 data bits discards the frame
        send_bit(1'b0, 1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1);
        #3 clr_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_dout", {24'd0, dout}, 32'd0);
        idle(2);
        clr_n = 1'b1;
        sin = 1'b1;
        idle(2);
        vcyc.delete();
        send_frame(8'h77, 1'b0, 1'b1, 1, 8'h77, 1'b0, 1'b0);
        idle(3);
        check("midrst_count", vcyc.size(), 32'd1);
        check("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
